// File: rtl/mem_readout_ctrl.sv
// Capture-RAM readout sequencer: walks events from address 0, prefixes each with a header word,
// streams over valid/ready. Define MEM_READOUT_CHKSUM_EN to append a per-event XOR trailer word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; counts and address cleared on accept
// S_HDR   | push header {8'hEB, event index} into the output buffer
// S_RD    | issue nwrite RAM reads for the current event
// S_DRAIN | last read lands in the buffer (plus trailer when enabled)
// S_FIN   | wait for the buffer to empty, pulse done
module mem_readout_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        nwrite,
    input  logic [7:0]        ntrigger,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [7:0]        ev_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_DRAIN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        nwrite_q, nwrite_d;
    logic [7:0]        ntrig_q, ntrig_d;
    logic [7:0]        ev_idx_q, ev_idx_d;
    logic [7:0]        ev_cnt_q, ev_cnt_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0]        occ_q, occ_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [DATA_W-1:0] buf_data_d [2];
    logic              buf_first_q [2];
    logic              buf_first_d [2];
    logic              buf_last_q [2];
    logic              buf_last_d [2];
`ifdef MEM_READOUT_CHKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
`endif

    logic              pop;
    logic [1:0]        occ_after;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_first;
    logic              push_last;
    logic              rd_en_c;
    logic              done_c;
    logic [DATA_W-1:0] hdr_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            nwrite_q        <= '0;
            ntrig_q         <= '0;
            ev_idx_q        <= '0;
            ev_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            buf_data_q      <= '{default: '0};
            buf_first_q     <= '{default: 1'b0};
            buf_last_q      <= '{default: 1'b0};
`ifdef MEM_READOUT_CHKSUM_EN
            chk_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            nwrite_q        <= nwrite_d;
            ntrig_q         <= ntrig_d;
            ev_idx_q        <= ev_idx_d;
            ev_cnt_q        <= ev_cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            buf_data_q      <= buf_data_d;
            buf_first_q     <= buf_first_d;
            buf_last_q      <= buf_last_d;
`ifdef MEM_READOUT_CHKSUM_EN
            chk_q           <= chk_d;
`endif
        end
    end

    always_comb begin
        hdr_word       = '0;
        hdr_word[15:0] = {8'hEB, ev_idx_q};
    end

    always_comb begin
        state_d         = state_q;
        nwrite_d        = nwrite_q;
        ntrig_d         = ntrig_q;
        ev_idx_d        = ev_idx_q;
        ev_cnt_d        = ev_cnt_q;
        rd_cnt_d        = rd_cnt_q;
        addr_d          = addr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        buf_data_d      = buf_data_q;
        buf_first_d     = buf_first_q;
        buf_last_d      = buf_last_q;
        push            = 1'b0;
        push_data       = '0;
        push_first      = 1'b0;
        push_last       = 1'b0;
        rd_en_c         = 1'b0;
        done_c          = 1'b0;
        pop             = (occ_q != 2'd0) && out_ready;
        occ_after       = occ_q - {1'b0, pop};
`ifdef MEM_READOUT_CHKSUM_EN
        chk_d           = chk_q;
`endif

        // RAM data returns one cycle after the strobe; the issue rule reserved its slot
        if (inflight_q) begin
            push      = 1'b1;
            push_data = ram_rdata;
`ifdef MEM_READOUT_CHKSUM_EN
            chk_d     = chk_q ^ ram_rdata;
`else
            push_last = inflight_last_q;
`endif
        end

        if (pop && buf_last_q[rd_ptr_q]) begin
            ev_cnt_d = ev_cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nwrite_d = nwrite;
                    ntrig_d  = ntrigger;
                    ev_cnt_d = '0;
                    ev_idx_d = '0;
                    addr_d   = '0;
                    state_d  = (nwrite == 8'd0 || ntrigger == 8'd0) ? S_FIN : S_HDR;
                end
            end
            S_HDR: begin
                if (occ_after < 2'd2) begin
                    push       = 1'b1;
                    push_data  = hdr_word;
                    push_first = 1'b1;
                    rd_cnt_d   = '0;
`ifdef MEM_READOUT_CHKSUM_EN
                    chk_d      = '0;
`endif
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                if ((occ_after + {1'b0, inflight_q}) < 2'd2) begin
                    rd_en_c         = 1'b1;
                    addr_d          = addr_q + ADDR_W'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (rd_cnt_q == nwrite_q - 8'd1);
                    rd_cnt_d        = rd_cnt_q + 8'd1;
                    if (rd_cnt_q == nwrite_q - 8'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
`ifdef MEM_READOUT_CHKSUM_EN
                if (!inflight_q && occ_after < 2'd2) begin
                    push      = 1'b1;
                    push_data = chk_q;
                    push_last = 1'b1;
                    ev_idx_d  = ev_idx_q + 8'd1;
                    state_d   = ((ev_idx_q + 8'd1) == ntrig_q) ? S_FIN : S_HDR;
                end
`else
                ev_idx_d = ev_idx_q + 8'd1;
                state_d  = ((ev_idx_q + 8'd1) == ntrig_q) ? S_FIN : S_HDR;
`endif
            end
            S_FIN: begin
                if (occ_q == 2'd0) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        occ_d = occ_after + {1'b0, push};
        if (push) begin
            buf_data_d[wr_ptr_q]  = push_data;
            buf_first_d[wr_ptr_q] = push_first;
            buf_last_d[wr_ptr_q]  = push_last;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    assign ram_rd_en = rd_en_c;
    assign ram_addr  = addr_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_first = buf_first_q[rd_ptr_q];
    assign out_last  = buf_last_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE) && !done_c;
    assign done      = done_c;
    assign ev_cnt    = ev_cnt_q;

endmodule

// File: tb/tb_mem_readout_ctrl.sv
// Directed bench for mem_readout_ctrl: behavioural 1-cycle RAM, ready patterns, reset/abort cases.
module tb_mem_readout_ctrl;

`ifdef MEM_READOUT_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  nwrite = 8'd0;
    logic [7:0]  ntrigger = 8'd0;
    logic        ram_rd_en;
    logic [15:0] ram_addr;
    logic [15:0] ram_rdata = 16'hDEAD;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_first;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [7:0]  ev_cnt;

    mem_readout_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .nwrite(nwrite), .ntrigger(ntrigger),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .busy(busy), .done(done), .ev_cnt(ev_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ready_mode = 0;
    int ram_mode = 0;

    logic [15:0] cap_data [0:1023];
    logic        cap_first [0:1023];
    logic        cap_last [0:1023];
    int          cap_n = 0;
    int          last_xfer_cyc = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          rd_issued = 0;
    int          smp_xfer = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_first, prev_last;

    logic [15:0] exp_data [0:255];
    logic        exp_first [0:255];
    logic        exp_last [0:255];
    int          exp_n = 0;

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        if (ram_mode == 0) return a + 16'h0100;
        return 16'h0001 << a[3:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) ram_rdata <= ram_rd_en ? ram_val(ram_addr) : 16'hDEAD;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Stream monitor: records transfers, checks stall stability and the outstanding-read bound
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                n_checks++;
                if (!out_valid || out_data !== prev_data || out_first !== prev_first || out_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=%h f=%0b l=%0b expected v=1 d=%h f=%0b l=%0b",
                             out_valid, out_data, out_first, out_last, prev_data, prev_first, prev_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_first = out_first;
            prev_last  = out_last;
            if (out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (cap_n < 1024) begin
                    cap_data[cap_n]  = out_data;
                    cap_first[cap_n] = out_first;
                    cap_last[cap_n]  = out_last;
                end
                cap_n++;
                last_xfer_cyc = cyc;
                if (!out_first && !(CHK && out_last)) smp_xfer++;
            end
            if (ram_rd_en) begin
                rd_issued++;
                n_checks++;
                if (rd_issued - smp_xfer > 2) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d samples read-not-transferred, expected <= 2",
                             rd_issued - smp_xfer);
                end
            end
        end else begin
            prev_stall = 1'b0;
            rd_issued  = smp_xfer;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] nw, input logic [7:0] nt);
        @(posedge clk);
        #1 start = 1'b1;
        nwrite   = nw;
        ntrigger = nt;
        @(posedge clk);
        #1 start = 1'b0;
        nwrite   = 8'hAA;
        ntrigger = 8'h55;
    endtask

    task automatic wait_done(input int max, output int ncyc, output bit ok);
        ok   = 1'b0;
        ncyc = max;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done) begin
                ok   = 1'b1;
                ncyc = i;
                break;
            end
        end
    endtask

    task automatic build_expected(input int nw, input int nt);
        logic [15:0] v, x;
        exp_n = 0;
        for (int e = 0; e < nt; e++) begin
            exp_data[exp_n] = 16'hEB00 | 16'(e);
            exp_first[exp_n] = 1'b1;
            exp_last[exp_n] = 1'b0;
            exp_n++;
            x = '0;
            for (int s = 0; s < nw; s++) begin
                v = ram_val(16'(e * nw + s));
                exp_data[exp_n] = v;
                exp_first[exp_n] = 1'b0;
                exp_last[exp_n] = !CHK && (s == nw - 1);
                x ^= v;
                exp_n++;
            end
            if (CHK) begin
                exp_data[exp_n] = x;
                exp_first[exp_n] = 1'b0;
                exp_last[exp_n] = 1'b1;
                exp_n++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({ram_rd_en, ram_addr, out_valid, out_data, out_first, out_last, busy, done, ev_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rd=%0b a=%h v=%0b d=%h f=%0b l=%0b busy=%0b done=%0b ev=%0d expected all 0",
                     ram_rd_en, ram_addr, out_valid, out_data, out_first, out_last, busy, done, ev_cnt);
        end
    endtask

    task automatic test_stream(input string name, input int nw, input int nt, input int rmode, input bit mid_start);
        int  base, d0, n;
        bit  ok;
        ready_mode = rmode;
        build_expected(nw, nt);
        base = cap_n;
        d0   = done_cnt;
        pulse_start(8'(nw), 8'(nt));
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %0b expected 1", name, busy);
        end
        if (mid_start) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            nwrite   = 8'd7;
            ntrigger = 8'd9;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(3000, n, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done in %0d cycles expected done", name, n);
        end
        n_checks++;
        if (cyc !== last_xfer_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_latency: got done at %0d expected %0d", name, cyc, last_xfer_cyc + 1);
        end
        n_checks++;
        if (ev_cnt !== 8'(nt)) begin
            n_fail++;
            $display("FAIL %s ev_cnt: got %0d expected %0d", name, ev_cnt, nt);
        end
        n_checks++;
        if (cap_n - base !== exp_n) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", name, cap_n - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if ({cap_data[base+i], cap_first[base+i], cap_last[base+i]} !== {exp_data[i], exp_first[i], exp_last[i]}) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h f=%0b l=%0b expected %h f=%0b l=%0b", name, i,
                         cap_data[base+i], cap_first[base+i], cap_last[base+i], exp_data[i], exp_first[i], exp_last[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL %s after_done: got busy=%0b done=%0b pulses=%0d expected busy=0 done=0 pulses=1",
                     name, busy, done, done_cnt - d0);
        end
        ready_mode = 0;
    endtask

    task automatic test_basic();
        int base;
        base = cap_n;
        test_stream("basic", 4, 2, 0, 1'b0);
`ifndef MEM_READOUT_CHKSUM_EN
        n_checks++;
        if (cap_data[base] !== 16'hEB00 || cap_data[base+5] !== 16'hEB01 || cap_first[base+5] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_headers: got %h %h f=%0b expected eb00 eb01 f=1",
                     cap_data[base], cap_data[base+5], cap_first[base+5]);
        end
        n_checks++;
        if (cap_data[base+4] !== 16'h0103 || cap_last[base+4] !== 1'b1 || cap_data[base+9] !== 16'h0107 || cap_last[base+9] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_lasts: got %h l=%0b %h l=%0b expected 0103 l=1 0107 l=1",
                     cap_data[base+4], cap_last[base+4], cap_data[base+9], cap_last[base+9]);
        end
`endif
    endtask

    task automatic test_zero(input string name, input logic [7:0] nw, input logic [7:0] nt);
        int  v0, n;
        bit  ok;
        v0 = valid_cnt;
        pulse_start(nw, nt);
        wait_done(3, n, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_within_3: got no done in %0d cycles expected done", name, n);
        end
        n_checks++;
        if (ev_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL %s ev_cnt: got %0d expected 0", name, ev_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid_cnt !== v0) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy=%0b valid_cycles=%0d expected busy=0 valid_cycles=0",
                     name, busy, valid_cnt - v0);
        end
    endtask

    task automatic test_start_rst();
        pulse_start(8'd4, 8'd2);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        start    = 1'b1;
        nwrite   = 8'd4;
        ntrigger = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ram_rd_en, ram_addr, out_valid, out_data, out_first, out_last, busy, done, ev_cnt} !== '0) begin
            n_fail++;
            $display("FAIL start_rst_values: got rd=%0b a=%h v=%0b d=%h busy=%0b done=%0b ev=%0d expected all 0",
                     ram_rd_en, ram_addr, out_valid, out_data, busy, done, ev_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_rst_ignored: got busy=%0b valid=%0b expected busy=0 valid=0", busy, out_valid);
        end
    endtask

    task automatic test_rst_midflight();
        bit hit;
        hit = 1'b0;
        pulse_start(8'd4, 8'd2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && ram_rd_en) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midflight_window: got no cycle with valid and read expected one");
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ram_rd_en, ram_addr, out_valid, out_data, out_first, out_last, busy, done, ev_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midflight_reset_values: got rd=%0b a=%h v=%0b d=%h f=%0b l=%0b busy=%0b ev=%0d expected all 0",
                     ram_rd_en, ram_addr, out_valid, out_data, out_first, out_last, busy, ev_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        test_stream("after_rst", 4, 2, 0, 1'b0);
    endtask

`ifdef MEM_READOUT_CHKSUM_EN
    task automatic test_chksum();
        int base;
        ram_mode = 1;
        base = cap_n;
        test_stream("chksum", 3, 2, 1, 1'b0);
        n_checks++;
        if (cap_data[base+4] !== 16'h0007 || cap_last[base+4] !== 1'b1 || cap_last[base+3] !== 1'b0) begin
            n_fail++;
            $display("FAIL chksum_trailer: got %h l=%0b prev l=%0b expected 0007 l=1 prev l=0",
                     cap_data[base+4], cap_last[base+4], cap_last[base+3]);
        end
        ram_mode = 0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_stream("toggle", 4, 2, 1, 1'b0);
        test_stream("random", 5, 3, 2, 1'b0);
        test_zero("ntrig0", 8'd4, 8'd0);
        test_zero("nwrite0", 8'd0, 8'd3);
        test_stream("second_start", 4, 2, 0, 1'b1);
        test_start_rst();
        test_rst_midflight();
`ifdef MEM_READOUT_CHKSUM_EN
        test_chksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_readout_ctrl.md
Name: mem_readout_ctrl

Overview:
Sequences readout of the capture RAM after the trigger-capture write controller has filled it.
- Walks the RAM from address 0 in event order and prefixes each event with a header word.
- Streams words out over a valid/ready interface towards the host link.
- Owns the RAM read port and handles the 1-cycle RAM read latency under backpressure.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM/output data width; must be >= 16

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begin readout (driven from capture status rising edge)
nwrite  in  8  samples per event; latched on accepted start
ntrigger  in  8  number of events to read; latched on accepted start
ram_rd_en  out  1  RAM read strobe
ram_addr  out  ADDR_W  RAM read address
ram_rdata  in  DATA_W  RAM data; valid exactly 1 cycle after ram_rd_en
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_first  out  1  qualifies header word of an event
out_last  out  1  qualifies final word of an event
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse after final word transfers
ev_cnt  out  8  events fully transferred since start

Behaviour:
- Reset values:
  - ram_rd_en=0, ram_addr=0, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0, done=0, ev_cnt=0.
  - Output buffer empty; state IDLE.
  - rst mid-readout aborts immediately; in-flight RAM data is discarded.
- Transfer: a word transfers when out_valid && out_ready.
- out_data/out_first/out_last are held stable while out_valid && !out_ready.
- States:
  - IDLE: on start go to HDR and assert busy next cycle; latch nwrite/ntrigger; clear ev_cnt and event index. If latched nwrite==0 or ntrigger==0, go straight to FIN.
  - HDR: push header word {zero-pad, 8'hEB, event_index[7:0]} with out_first=1 into the output buffer; go to RD.
  - RD: issue nwrite reads at consecutive addresses.
    - Event e occupies addresses e*nwrite .. e*nwrite+nwrite-1.
    - ram_addr increments by 1 per issued read; it is not reset between events.
    - Returned data enters the output buffer; the last sample carries out_last=1.
    - When all reads are issued, go to DRAIN.
  - DRAIN: wait until every read of the event has returned and been written into the buffer.
    - When the last word of the event transfers, increment ev_cnt and the event index.
    - If event index == ntrigger go to FIN, else go to HDR.
  - FIN: wait until the output buffer is empty; pulse done for one cycle; deassert busy in the same cycle; go to IDLE.
- Output buffer and flow control:
  - Output buffer is a 2-entry skid/FIFO.
  - A read may issue only if (buffer occupancy + reads in flight) < 2. This guarantees no overflow under any out_ready pattern.
  - Sustained throughput is 1 word/cycle with out_ready held high.
  - Header insertion costs no extra bubble beyond the buffer rule.
- Address arithmetic is ADDR_W-bit and wraps modulo 2^ADDR_W; no error is flagged on wrap.
- start is ignored while busy=1, and also in the done cycle.
- start and rst in the same cycle: rst wins.
- nwrite/ntrigger changes while busy have no effect.

Optional Feature:
MEM_READOUT_CHKSUM_EN
- Defined:
  - After the nwrite samples of each event, emit one trailer word = XOR of that event's sample words; the header is excluded.
  - out_last moves from the last sample to the trailer.
  - An event is nwrite+2 words.
  - The trailer is inserted from the DRAIN state and obeys the same buffer rule.
- Undefined: no trailer; an event is nwrite+1 words; no checksum logic is synthesized.

Test Plan:
- nwrite=4, ntrigger=2, RAM[i]=i+0x100, out_ready=1 -> 10 words: 0x00EB00, 0x100..0x103, 0x00EB01, 0x104..0x107.
  - out_first on words 0 and 5; out_last on words 4 and 9.
  - done pulses 1 cycle after the last transfer; ev_cnt=2.
- Same stimulus with out_ready toggling 1/0 every cycle, plus a random-stall run -> identical word sequence; no data held changes while stalled; never more than 2 reads outstanding+buffered.
- ntrigger=0 (and separately nwrite=0) -> no out_valid; done pulses within 3 cycles of start; busy returns low.
- Second start pulse mid-readout, and start coincident with rst -> ignored and reset respectively; the word stream is unaffected or aborted cleanly; all outputs at reset values next cycle.
- rst asserted while out_valid=1 and a read is in flight -> next cycle all outputs at reset values; a new start yields a correct stream from address 0.
- With MEM_READOUT_CHKSUM_EN, nwrite=3, data 0x0001, 0x0002, 0x0004 -> trailer 0x0007 with out_last; the sample before it has out_last=0.
